// File: rtl/next_hop_select.sv
// Scans the neighbour table and returns the ID with the highest Q-value.
// Optional macro TIE_BREAK_ENERGY_EN: equal Q-values are resolved by higher remaining energy.
module next_hop_select #(
   parameter int WORD_WIDTH = 16,
   parameter int MEM_DEPTH  = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] neighborCount,
   output logic [WORD_WIDTH-1:0] rd_index,
   output logic                  rd_en,
   input  logic [WORD_WIDTH-1:0] mSourceID,
   input  logic [WORD_WIDTH-1:0] mEnergyLeft,
   input  logic [WORD_WIDTH-1:0] mQValue,
   output logic [WORD_WIDTH-1:0] nextHopID,
   output logic [WORD_WIDTH-1:0] nextHopQ,
   output logic                  found,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = $clog2(MEM_DEPTH + 1);
   localparam logic [WORD_WIDTH-1:0] DEPTH_WORD = WORD_WIDTH'(MEM_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CMP   = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      r_index;
   logic [WORD_WIDTH-1:0] r_best_q;
   logic [WORD_WIDTH-1:0] r_best_id;
   logic                  r_found_scan;
   logic [WORD_WIDTH-1:0] r_rd_index;
   logic                  r_rd_en;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_found;
   logic [WORD_WIDTH-1:0] r_next_hop_id;
   logic [WORD_WIDTH-1:0] r_next_hop_q;

   logic [CNT_W-1:0]      w_clamp;
   logic [CNT_W-1:0]      w_index_inc;
   logic                  w_last;
   logic                  w_replace;

`ifdef TIE_BREAK_ENERGY_EN
   logic [WORD_WIDTH-1:0] r_best_e;
`else
   logic                  w_unused_energy;
   assign w_unused_energy = ^mEnergyLeft;
`endif

   // Count clamp and scan-progress helpers
   always_comb begin
      w_clamp = {CNT_W{1'b0}};
      if (neighborCount > DEPTH_WORD) begin
         w_clamp = CNT_W'(DEPTH_WORD);
      end else begin
         w_clamp = CNT_W'(neighborCount);
      end
      w_index_inc = r_index + {{(CNT_W-1){1'b0}}, 1'b1};
      w_last      = (w_index_inc == r_count);
   end

   // Replacement decision for the entry read this cycle; first entry always wins
   always_comb begin
      w_replace = 1'b0;
      if (!r_found_scan) begin
         w_replace = 1'b1;
      end else if (mQValue > r_best_q) begin
         w_replace = 1'b1;
`ifdef TIE_BREAK_ENERGY_EN
      end else if ((mQValue == r_best_q) && (mEnergyLeft > r_best_e)) begin
         w_replace = 1'b1;
`endif
      end else begin
         w_replace = 1'b0;
      end
   end

   // Scan FSM, best-entry tracking and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_count       <= {CNT_W{1'b0}};
         r_index       <= {CNT_W{1'b0}};
         r_best_q      <= {WORD_WIDTH{1'b0}};
         r_best_id     <= {WORD_WIDTH{1'b1}};
         r_found_scan  <= 1'b0;
         r_rd_index    <= {WORD_WIDTH{1'b0}};
         r_rd_en       <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_found       <= 1'b0;
         r_next_hop_id <= {WORD_WIDTH{1'b1}};
         r_next_hop_q  <= {WORD_WIDTH{1'b0}};
`ifdef TIE_BREAK_ENERGY_EN
         r_best_e      <= {WORD_WIDTH{1'b0}};
`endif
      end else begin
         r_done  <= 1'b0;
         r_rd_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_count      <= w_clamp;
                  r_index      <= {CNT_W{1'b0}};
                  r_best_q     <= {WORD_WIDTH{1'b0}};
                  r_best_id    <= {WORD_WIDTH{1'b1}};
                  r_found_scan <= 1'b0;
                  r_rd_index   <= {WORD_WIDTH{1'b0}};
                  r_busy       <= 1'b1;
`ifdef TIE_BREAK_ENERGY_EN
                  r_best_e     <= {WORD_WIDTH{1'b0}};
`endif
                  if (w_clamp == {CNT_W{1'b0}}) begin
                     // Empty table: publish the "no hop" result straight away
                     r_state       <= S_FIN;
                     r_done        <= 1'b1;
                     r_found       <= 1'b0;
                     r_next_hop_id <= {WORD_WIDTH{1'b1}};
                     r_next_hop_q  <= {WORD_WIDTH{1'b0}};
                  end else begin
                     r_state <= S_ISSUE;
                     r_rd_en <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               r_state <= S_CMP;
            end
            S_CMP: begin
               if (w_replace) begin
                  r_best_q  <= mQValue;
                  r_best_id <= mSourceID;
`ifdef TIE_BREAK_ENERGY_EN
                  r_best_e  <= mEnergyLeft;
`endif
               end else begin
                  r_best_q  <= r_best_q;
               end
               r_found_scan <= 1'b1;
               r_index      <= w_index_inc;
               if (w_last) begin
                  // Result is published on entry to FIN so it is valid alongside done
                  r_state       <= S_FIN;
                  r_done        <= 1'b1;
                  r_found       <= 1'b1;
                  r_next_hop_id <= w_replace ? mSourceID : r_best_id;
                  r_next_hop_q  <= w_replace ? mQValue : r_best_q;
               end else begin
                  r_state    <= S_ISSUE;
                  r_rd_en    <= 1'b1;
                  r_rd_index <= WORD_WIDTH'(w_index_inc);
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_index  = r_rd_index;
   assign rd_en     = r_rd_en;
   assign nextHopID = r_next_hop_id;
   assign nextHopQ  = r_next_hop_q;
   assign found     = r_found;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: doc/next_hop_select.md
# next_hop_select

Downstream consumer of the Q-table update stage in the EER-RL routing datapath. On a start pulse it scans the neighbour table written by the Q-table updater (entries 0..neighborCount-1). It returns the neighbour ID with the highest Q-value, which the packet builder uses as the next hop for data forwarding. The scan is a sequential FSM issuing one synchronous memory read per entry.

## Interface
- WORD_WIDTH, 16, width of IDs, energy and Q-value words (Q-value/energy unsigned Q2.14: 16'h4000 = 1.0).
- MEM_DEPTH, 2048, neighbour table depth; neighborCount clamped to this.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start pulse, sampled only in IDLE.
- neighborCount  in  WORD_WIDTH  number of valid table entries; latched on start.
- rd_index  out  WORD_WIDTH  table read address.
- rd_en  out  1  read strobe; table returns data the next cycle.
- mSourceID  in  WORD_WIDTH  neighbour ID read data.
- mEnergyLeft  in  WORD_WIDTH  neighbour energy read data.
- mQValue  in  WORD_WIDTH  neighbour Q-value read data.
- nextHopID  out  WORD_WIDTH  selected neighbour ID.
- nextHopQ  out  WORD_WIDTH  Q-value of the selected neighbour.
- found  out  1  at least one entry was scanned.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse, result valid.

## Operation
- Reset values:
  - rd_index=0, rd_en=0, busy=0, done=0, found=0.
  - nextHopID=16'hFFFF, nextHopQ=0.
  - State IDLE, internal index and best registers cleared.
- States: IDLE, ISSUE, CMP, FIN.
- IDLE:
  - Action on en=1:
    - Latch count = min(neighborCount, MEM_DEPTH).
    - Clear best registers: bestQ=0, bestID=16'hFFFF, bestE=0, found=0.
    - Set index=0 and busy=1.
  - Next state: FIN if count==0, else ISSUE.
- ISSUE: drive rd_index=index, rd_en=1 for exactly this cycle; next state CMP.
- CMP:
  - Read data is valid this cycle.
  - Replacement rule: if found==0 or mQValue > bestQ (unsigned compare), load best* from read data and set found=1.
  - Equal Q keeps the earlier (lower-index) entry, unless TIE_BREAK_ENERGY_EN is defined.
  - index += 1; next state FIN if index+1 == count, else ISSUE.
- FIN:
  - Copy bestID/bestQ to nextHopID/nextHopQ.
  - Pulse done=1 for one cycle and clear busy; next state IDLE.
- Output hold: nextHopID/nextHopQ/found hold their values until the next FIN.
- Start while busy: en during ISSUE/CMP/FIN is ignored, with no queuing.
- Latching: changes to neighborCount mid-scan are ignored.
- Reset mid-scan: rst=1 in any state returns to the reset values next edge. No done is emitted.
- Reset priority: rst has priority over en in the same cycle.
- No arithmetic overflow: index never exceeds count ≤ MEM_DEPTH. rd_index is zero-extended to WORD_WIDTH.

## Timing
- Reference point: en sampled high at edge 0.
- N≥1:
  - ISSUE entry k occupies cycle 1+2k; CMP entry k occupies cycle 2+2k.
  - done=1 in cycle 2N+1, so latency is 2N+1 cycles.
- N=0: FIN in cycle 1, done in cycle 1, found=0, nextHopID=16'hFFFF.
- Back-to-back scans: the earliest next accepted en is the cycle after done.
- Read path: read data is sampled exactly one cycle after rd_en; memory must have 1-cycle synchronous read.

## Configuration
- TIE_BREAK_ENERGY_EN:
  - Defined: in CMP, mQValue == bestQ with mEnergyLeft > bestE also replaces the best entry.
  - Undefined: equal Q never replaces, so the lowest index wins. The bestE register and its comparator are compiled out.

## Test plan
- Reset then N=0: en=1 → done in cycle 1, found=0, nextHopID=16'hFFFF, nextHopQ=0, rd_en never asserted.
- N=3, table {ID1 Q 16'h3000, ID2 Q 16'h8000, ID3 Q 16'h4000} → done in cycle 7, nextHopID=2, nextHopQ=16'h8000, rd_index sequence 0,1,2.
- Tie: N=2, {ID5 Q 16'h4000 E 16'h2000, ID6 Q 16'h4000 E 16'h6000} → nextHopID=5 without the macro, 6 with TIE_BREAK_ENERGY_EN.
- Busy guard: N=4, second en pulse at cycle 3 and neighborCount changed to 1 at cycle 2 → single done at cycle 9, all 4 entries read.
- Reset mid-scan: N=4, rst=1 at cycle 4 → next cycle busy=0, nextHopID=16'hFFFF, no done. A fresh en then completes normally at cycle 2N+1.
- Clamp: neighborCount=16'hFFFF with MEM_DEPTH=2048 → last rd_index=2047, done in cycle 4097.
